// File: rtl/sensor_ctrl.sv
// Measurement sequencer for the inverter delay-line timing sensor: gates the sensor,
// calibrates a reference sample, counts mismatching samples over a window and raises a sticky alarm.
module sensor_ctrl #(
    parameter int CNT_W       = 8,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic [CNT_W-1:0] thresh,
    input  logic             clr,
    input  logic             sens_i,
    output logic             sens_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             alarm
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TMR_W = (CNT_W > SET_W) ? CNT_W : SET_W;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        CAL,
        MEASURE,
        DONE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   ref_q;
    logic [CNT_W-1:0]       win_q;
    logic [CNT_W-1:0]       thr_q;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       win_ext;
    logic                   settle_last;
    logic                   meas_last;

    // sens_i is asynchronous to clk, so only the last synchronizer stage is ever observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value,
            // which is what makes this a shift chain rather than a single wire.
            sync_q <= {sync_q[SYNC_STAGES-2:0], sens_i};
        end
    end

    assign s           = sync_q[SYNC_STAGES-1];
    assign win_ext     = TMR_W'(win_q);
    assign settle_last = (timer == TMR_W'(SETTLE - 1));
    assign meas_last   = (timer == win_ext - TMR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d = state_q;
        sens_en = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = WARMUP;
            end
            WARMUP: begin
                sens_en = 1'b1;
                if (settle_last) state_d = CAL;
            end
            CAL: begin
                sens_en = 1'b1;
                state_d = (win_q == '0) ? DONE : MEASURE;
            end
            MEASURE: begin
                sens_en = 1'b1;
                if (meas_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase timer restarts on every state change, so it counts cycles spent in the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state_d != state_q) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            thr_q   <= '0;
            ref_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                win_q <= win_len;
                thr_q <= thresh;
            end
            if (state_q == CAL) begin
                ref_q   <= s;
                err_cnt <= '0;
            end else if (state_q == MEASURE && s != ref_q && err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    // Setting the alarm in DONE takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else if (state_q == DONE && thr_q != '0 && err_cnt >= thr_q) begin
            alarm <= 1'b1;
        end else if (clr) begin
            alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sensor_ctrl.sv
// Randomized scoreboard bench for sensor_ctrl: each run's sens_i pattern is planned up front,
// its expected result queued, and a negedge monitor compares outputs every cycle.
module tb_sensor_ctrl;

    localparam int CNT_W       = 8;
    localparam int SETTLE      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] win_len = '0;
    logic [CNT_W-1:0] thresh = '0;
    logic             clr = 1'b0;
    logic             sens_i = 1'b0;
    logic             sens_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic             alarm;

    sensor_ctrl #(
        .CNT_W      (CNT_W),
        .SETTLE     (SETTLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .win_len(win_len),
        .thresh (thresh),
        .clr    (clr),
        .sens_i (sens_i),
        .sens_en(sens_en),
        .busy   (busy),
        .done   (done),
        .err_cnt(err_cnt),
        .alarm  (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;    // edge at which start is accepted
        int d;    // edge after which the DUT sits in DONE
        int err;
        int thr;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_err = 0;
    bit   exp_alarm = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: at each negedge compare against the head of the scoreboard.
    always @(negedge clk) begin
        bit   has_h;
        exp_t h;
        int   e;
        if (rst_n) begin
            e     = edge_n;
            has_h = (exp_q.size() > 0);
            if (has_h) h = exp_q[0];
            check("busy",    busy,    32'(has_h && e >= h.k && e <= h.d));
            check("sens_en", sens_en, 32'(has_h && e >= h.k && e <  h.d));
            check("done",    done,    32'(has_h && e == h.d));
            if (!has_h || e < h.k + SETTLE + 1) check("err_cnt_held", err_cnt, exp_err);
            if (has_h && e == h.d) begin
                check("err_cnt", err_cnt, h.err);
                exp_err = h.err;
            end
            check("alarm", alarm, 32'(exp_alarm));
            if (has_h && e == h.d && h.thr != 0 && h.err >= h.thr) exp_alarm = 1'b1;
            else if (clr) exp_alarm = 1'b0;
            if (has_h && e == h.d) void'(exp_q.pop_front());
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_sens_en"}, sens_en, 0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_alarm"},   alarm,   0);
    endtask

    // Called just after a posedge. mode: 0 const cval, 1 random, 2 toggle,
    // 3 ref then five opposite samples, 4 ref then all opposite.
    task automatic run(input int w, input int t, input int mode, input bit cval,
                       input int clr_mode, input bit pulses, input bit hold, input int abort_at);
        bit   plan[$];
        exp_t x;
        int   r, len, e;
        x.k = edge_n + 1;
        x.d = x.k + SETTLE + 1 + w;
        x.thr = t;
        r   = SETTLE + 1 - SYNC_STAGES;
        len = SETTLE + 4 + w;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       plan.push_back(cval);
                1:       plan.push_back(1'($urandom_range(0, 1)));
                2:       plan.push_back(1'(i % 2));
                3:       plan.push_back(i > r && i <= r + 5);
                default: plan.push_back(i > r);
            endcase
        end
        x.err = 0;
        for (int j = 1; j <= w; j++)
            if (plan[r+j] != plan[r] && x.err < SAT) x.err++;
        exp_q.push_back(x);

        win_len = CNT_W'(w);
        thresh  = CNT_W'(t);
        start   = 1'b1;
        clr     = 1'b0;
        sens_i  = plan[0];
        for (int i = 1; i < len; i++) begin
            @(posedge clk);
            #1;
            e = edge_n;
            if (abort_at != 0 && i == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort");
                exp_q.delete();
                exp_err   = 0;
                exp_alarm = 1'b0;
                start     = 1'b0;
                clr       = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            sens_i  = plan[i];
            win_len = CNT_W'($urandom);
            thresh  = CNT_W'($urandom);
            if (hold) start = 1'b1;
            else if (pulses && e < x.d) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            clr = (clr_mode == 2 && e == x.d) || (clr_mode == 1 && $urandom_range(0, 7) == 0);
        end
        clr = 1'b0;
    endtask

    task automatic idle(input int n, input bit c);
        start = 1'b0;
        clr   = c;
        @(posedge clk);
        #1 clr = 1'b0;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #3 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3, 1'b0);

        // Constant sens_i: no mismatches, no alarm.
        run(10, 3, 0, 1'b1, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        // Five mismatching samples over threshold, then clear leaves err_cnt alone.
        run(10, 3, 3, 1'b0, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        // Full-length windows: toggling with alarm disabled, then all-mismatch at the threshold edge.
        run(255, 0, 2, 1'b0, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        run(255, 255, 4, 1'b0, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b1);
        // Empty window with start pulses while busy.
        run(0, 5, 1, 1'b0, 0, 1'b1, 1'b0, 0);
        idle(3, 1'b0);
        // Reset mid-measurement, then a normal run.
        run(20, 2, 1, 1'b0, 0, 1'b0, 1'b0, 8);
        idle(2, 1'b0);
        run(6, 1, 1, 1'b0, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b1);
        // Clear during DONE loses to the set, and start held high chains runs.
        run(8, 2, 4, 1'b0, 2, 1'b0, 1'b1, 0);
        run(5, 0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
        run(3, 1, 1, 1'b0, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);

        for (int n = 0; n < 25; n++) begin
            w = $urandom_range(0, 40);
            run(w, $urandom_range(0, w + 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        idle(4, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
